// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving one external full adder.
// Operands are shifted out LSB-first, one bit per clock. The FA carry-out is
// registered back into its carry-in, and the sum bits are collected
// MSB-inward into the result register.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in0,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c_in,
  input  logic             fa_s,
  input  logic             fa_c_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_a_s;
  logic             fa_b_s;
  logic             fa_c_in_s;

  // Control FSM plus operand shifters, carry loop and result collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= c_in0;
            cnt_r   <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= fa_c_out;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            // Last bit: the final carry becomes the result's top bit.
            c_out_r <= fa_c_out;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FA operand drive: live bits only while running, quiet zeros otherwise.
  always_comb begin
    fa_a_s    = 1'b0;
    fa_b_s    = 1'b0;
    fa_c_in_s = 1'b0;
    if (state_r == RUN) begin
      fa_a_s    = a_sh_r[0];
      fa_b_s    = b_sh_r[0];
      fa_c_in_s = carry_r;
    end else begin
      fa_a_s    = 1'b0;
      fa_b_s    = 1'b0;
      fa_c_in_s = 1'b0;
    end
  end

  assign fa_a    = fa_a_s;
  assign fa_b    = fa_b_s;
  assign fa_c_in = fa_c_in_s;
  assign busy    = busy_r;
  assign done    = done_r;
  assign sum     = sum_r;
  assign c_out   = c_out_r;

endmodule
